// File: rtl/phy_defs_pkg.sv
// rtl/phy_defs_pkg.sv - shared PHY line symbols and link-state encoding
//
// Package phy_defs. Holds the symbol values and the 1-bit INIT/ACTIVE state
// encoding used by both the transmit serializer and the receive path, so the
// comma the receiver hunts for is the comma the transmitter sends.
//
// Contents:
//   COM_SYM      comma symbol, used for link alignment after reset
//   IDLE_SYM     alternative filler symbol for the ACTIVE state
//   phy_state_t  INIT (sending alignment commas) / ACTIVE (carrying data)

package phy_defs;

  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] IDLE_SYM = 8'h7C;

  typedef enum logic {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_t;

endpackage

// File: rtl/piso_shreg8.sv
// rtl/piso_shreg8.sv - 8-bit parallel-in serial-out shift register, MSB first
//
// Ports:
//   clk      in   shift clock, rising edge
//   reset    in   asynchronous, active-high; clears the register to 0
//   load     in   capture par_in on this edge (takes priority over shift)
//   shift    in   shift one place toward the MSB, filling with 0
//   par_in   in   [7:0] parallel byte to capture
//   msb_out  out  current MSB, straight from the register

module piso_shreg8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] par_in,
  output logic       msb_out
);

  logic [7:0] shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= 8'h00;
    end else if (load) begin
      shreg <= par_in;
    end else if (shift) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign msb_out = shreg[7];

endmodule

// File: rtl/phy_tx_serializer.sv
// rtl/phy_tx_serializer.sv - PHY transmit byte serializer with link-init commas
//
// After reset the line carries INIT_COMS comma symbols, then one byte slot
// every 8 bit clocks. Each slot carries the offered byte, or a filler symbol
// when nothing valid is offered at the slot edge.
//
// Build option: define PHY_TX_IDLE_EN to use IDLE_SYM as the ACTIVE-state
// filler; otherwise the filler is COM_SYM. Init behaviour is the same in both.
//
// Parameters:
//   INIT_COMS    number of alignment commas sent after reset (>= 1)
//
// Ports:
//   clk_8f       in   bit clock, rising edge
//   reset        in   asynchronous, active-high
//   data_in0     in   [7:0] byte to send, held while data_ready0 is high
//   valid_in0    in   data_in0 holds a real byte
//   data_ready0  out  one-cycle slot strobe; byte taken at the edge ending it
//   serial_out0  out  serial line, MSB first, registered
//   tx_active    out  init commas are done, data slots are open

module phy_tx_serializer
  import phy_defs::*;
#(
  parameter int INIT_COMS = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  output logic       data_ready0,
  output logic       serial_out0,
  output logic       tx_active
);

  // Wide enough to hold INIT_COMS, where the counter parks once ACTIVE.
  localparam int                CNT_W    = (INIT_COMS < 2) ? 1 : $clog2(INIT_COMS + 1);
  localparam logic [CNT_W-1:0]  LAST_COM = CNT_W'(INIT_COMS - 1);

`ifdef PHY_TX_IDLE_EN
  localparam logic [7:0] FILLER_SYM = IDLE_SYM;
`else
  localparam logic [7:0] FILLER_SYM = COM_SYM;
`endif

  logic [2:0]       bit_cnt;
  logic             load_edge;
  phy_state_t       state;
  phy_state_t       state_nxt;
  logic [CNT_W-1:0] init_cnt;
  logic [CNT_W-1:0] init_cnt_nxt;
  logic [7:0]       next_byte;

  // bit_cnt resets to 7 so the very first edge after reset is a load edge and
  // the first comma starts without a dead byte on the line.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd7;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign load_edge = (bit_cnt == 3'd7);

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // The load that moves us to ACTIVE still sends a comma; data is first taken
  // at the next load edge, one full byte later.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    next_byte    = COM_SYM;
    case (state)
      ST_INIT: begin
        if (load_edge) begin
          init_cnt_nxt = init_cnt + 1'b1;
          if (init_cnt == LAST_COM) begin
            state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        next_byte = valid_in0 ? data_in0 : FILLER_SYM;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Shift is always enabled; the register only ever holds the byte in flight.
  piso_shreg8 u_piso (
    .clk     (clk_8f),
    .reset   (reset),
    .load    (load_edge),
    .shift   (1'b1),
    .par_in  (next_byte),
    .msb_out (serial_out0)
  );

  assign data_ready0 = (state == ST_ACTIVE) && load_edge;
  assign tx_active   = (state == ST_ACTIVE);

endmodule

// File: tb/tb_phy_tx_serializer.sv
// tb/tb_phy_tx_serializer.sv - directed self-checking bench for phy_tx_serializer

module tb_phy_tx_serializer;

  logic       clk_8f;
  logic       reset;
  logic [7:0] data_in0;
  logic       valid_in0;
  logic       data_ready0;
  logic       serial_out0;
  logic       tx_active;

  int n_cmp;
  int n_err;

`ifdef PHY_TX_IDLE_EN
  localparam logic [7:0] EXP_FILL = 8'h7C;
`else
  localparam logic [7:0] EXP_FILL = 8'hBC;
`endif

  phy_tx_serializer #(.INIT_COMS(4)) dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_in0    (data_in0),
    .valid_in0   (valid_in0),
    .data_ready0 (data_ready0),
    .serial_out0 (serial_out0),
    .tx_active   (tx_active)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then observe at the following falling edge.
  task automatic tick();
    @(posedge clk_8f);
    @(negedge clk_8f);
  endtask

  // Entered just after reset release (at a falling edge, valid_in0=0).
  // Leaves the bench in the first data_ready0 cycle.
  task automatic init_seq(input string tag);
    logic [31:0] bits;
    int          rdy_early;
    bits      = '0;
    rdy_early = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      bits = {bits[30:0], serial_out0};
      if (k < 32) rdy_early += int'(data_ready0);
      if (k == 24) check({tag, "_txact_pre"}, 32'(tx_active), 32'd0);
      if (k == 25) check({tag, "_txact_rise"}, 32'(tx_active), 32'd1);
    end
    check({tag, "_com0"}, 32'(bits[31:24]), 32'hBC);
    check({tag, "_com1"}, 32'(bits[23:16]), 32'hBC);
    check({tag, "_com2"}, 32'(bits[15:8]),  32'hBC);
    check({tag, "_com3"}, 32'(bits[7:0]),   32'hBC);
    check({tag, "_rdy_early"}, 32'(rdy_early), 32'd0);
    check({tag, "_rdy_first"}, 32'(data_ready0), 32'd1);
  endtask

  // Entered in a data_ready0 cycle. Offers (v,d) at the slot edge, captures the
  // 8 line bits that follow and leaves in the next data_ready0 cycle. With junk
  // set, 8'h55/valid is driven mid-slot and must not reach the line.
  task automatic slot_byte(input string tag, input logic v, input logic [7:0] d,
                           input logic junk, output logic [7:0] got);
    int rdy_mid;
    rdy_mid   = 0;
    got       = '0;
    valid_in0 = v;
    data_in0  = d;
    for (int k = 1; k <= 8; k++) begin
      tick();
      got = {got[6:0], serial_out0};
      if (k < 8) rdy_mid += int'(data_ready0);
      if (k == 1) begin
        valid_in0 = 1'b0;
        data_in0  = 8'h00;
      end
      if (junk && k == 4) begin
        valid_in0 = 1'b1;
        data_in0  = 8'h55;
      end
      if (junk && k == 6) begin
        valid_in0 = 1'b0;
        data_in0  = 8'hAA;
      end
      if (k == 7) begin
        valid_in0 = 1'b0;
        data_in0  = 8'h00;
      end
    end
    check({tag, "_rdy_mid"}, 32'(rdy_mid), 32'd0);
    check({tag, "_rdy_next"}, 32'(data_ready0), 32'd1);
  endtask

  initial begin
    logic [7:0]  got;
    logic [15:0] pair;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    valid_in0 = 1'b0;
    data_in0  = 8'h00;

    // 1: reset held 3 cycles, then init commas
    repeat (3) tick();
    check("rst_serial", 32'(serial_out0), 32'd0);
    check("rst_ready",  32'(data_ready0), 32'd0);
    check("rst_txact",  32'(tx_active),   32'd0);
    reset = 1'b0;
    init_seq("init");

    // 2: single byte A5
    slot_byte("a5", 1'b1, 8'hA5, 1'b0, got);
    check("a5_bits", 32'(got), 32'hA5);

    // 3: back-to-back FF then 00, continuous 16-bit capture
    slot_byte("ff", 1'b1, 8'hFF, 1'b0, got);
    pair[15:8] = got;
    slot_byte("00", 1'b1, 8'h00, 1'b0, got);
    pair[7:0] = got;
    check("ff00_bits", 32'(pair), 32'hFF00);

    // 4: empty slot gives the filler, next valid byte intact
    slot_byte("fill", 1'b0, 8'h00, 1'b0, got);
    check("fill_bits", 32'(got), 32'(EXP_FILL));
    slot_byte("3c", 1'b1, 8'h3C, 1'b0, got);
    check("3c_bits", 32'(got), 32'h3C);

    // 6: mid-slot toggles are ignored
    slot_byte("junk81", 1'b1, 8'h81, 1'b1, got);
    check("junk81_bits", 32'(got), 32'h81);
    slot_byte("junkfill", 1'b0, 8'h00, 1'b1, got);
    check("junkfill_bits", 32'(got), 32'(EXP_FILL));

    // 5: reset in the bit_cnt==3 cycle of byte C3
    valid_in0 = 1'b1;
    data_in0  = 8'hC3;
    repeat (4) tick();
    valid_in0 = 1'b0;
    data_in0  = 8'h00;
    check("c3_txact_pre", 32'(tx_active), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("c3_rst_serial", 32'(serial_out0), 32'd0);
    check("c3_rst_txact",  32'(tx_active),   32'd0);
    check("c3_rst_ready",  32'(data_ready0), 32'd0);
    @(negedge clk_8f);
    repeat (2) tick();
    reset = 1'b0;
    init_seq("reinit");
    slot_byte("post", 1'b1, 8'h5A, 1'b0, got);
    check("post_bits", 32'(got), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
